// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: widths, opcodes, FSM states
// and the packed result payload handed to the response port.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned NREG   = 4;
  localparam int unsigned REG_AW = $clog2(NREG);
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Captured ALU result plus the register it was written to.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              cout;
    logic              zero;
    logic [REG_AW-1:0] rd;
  } res_t;

endpackage

// File: rtl/alu_regfile.sv
// 4x4-bit working register file.
// Ports: clk/rst_n (async active-low clear), one synchronous write port
// (we/waddr/wdata), two combinational operand reads (raddr1/rdata1,
// raddr2/rdata2) and a combinational debug read (dbg_sel/dbg_data).
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf [NREG];

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf[i] <= '0;
      end
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  // Reads always return committed contents.
  assign rdata1   = rf[raddr1];
  assign rdata2   = rf[raddr2];
  assign dbg_data = rf[dbg_sel];

endmodule

// File: rtl/alu_issue_seq.sv
// Command sequencer + register file in front of the external 4-bit ALU.
// Ports:
//   cmd_*   : valid/ready command input (load-immediate or ALU op)
//   alu_a/b/op : registered operands/opcode to the ALU; alu_y/cout/zero back
//   res_*   : back-pressurable result beat (data, carry, zero, dest index)
//   dbg_sel/dbg_data : combinational register-file peek
// cmd_ready and dbg_data are combinational; every other output is registered.
module alu_issue_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ld,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic              res_zero,
  output logic [REG_AW-1:0] res_rd,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q;
  state_e            state_d;
  logic [REG_AW-1:0] rd_q;
  res_t              res_q;

  logic              take;
  logic              accept;
  logic              accept_ld;
  logic              accept_alu;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  // Handshake decode: a pending result being taken frees the slot this edge.
  assign take       = (state_q == RESP) && res_ready;
  assign cmd_ready  = rst_n && ((state_q == IDLE) || take);
  assign accept     = cmd_valid && cmd_ready;
  assign accept_ld  = accept && cmd_ld;
  assign accept_alu = accept && !cmd_ld;

  // Write port: EXEC commits the ALU result, otherwise an accepted load.
  // The two never coincide because cmd_ready is low in EXEC.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = cmd_rd;
    rf_wdata = cmd_imm;
    if (state_q == EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_y;
    end else if (accept_ld) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr1   (cmd_rs1),
    .rdata1   (rs1_data),
    .raddr2   (cmd_rs2),
    .rdata2   (rs2_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; loads never leave IDLE/RESP on their own.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_alu) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) state_d = accept_alu ? EXEC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ALU operand launch and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      res_valid <= 1'b0;
    end else begin
      if (accept_alu) begin
        alu_a  <= rs1_data;
        alu_b  <= rs2_data;
        alu_op <= cmd_op;
        rd_q   <= cmd_rd;
      end
      if (state_q == EXEC) begin
        res_q.data <= alu_y;
        res_q.cout <= alu_cout;
        res_q.zero <= alu_zero;
        res_q.rd   <= rd_q;
        res_valid  <= 1'b1;
      end else if (take) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign res_data = res_q.data;
  assign res_cout = res_q.cout;
  assign res_zero = res_q.zero;
  assign res_rd   = res_q.rd;

endmodule
